// File: rtl/stream_frame_tracker_if.sv
//==============================================================================
// Module      : stream_frame_tracker_if
// Description : Beat-stream bundle between the upstream buffer, the frame
//               tracker and its downstream consumer.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface stream_frame_tracker_if #(
    parameter int CHANNELS     = 1,
    parameter int DATA_WIDTH   = 16,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
);
    localparam int COL_W = $clog2(FRAME_WIDTH);
    localparam int ROW_W = $clog2(FRAME_HEIGHT);

    logic [CHANNELS-1:0][DATA_WIDTH-1:0] channels_i;
    logic                                valid_i;
    logic                                sof_i;
    logic                                stall_o;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0] channels_o;
    logic                                valid_o;
    logic                                sof_o;
    logic                                eol_o;
    logic                                eof_o;
    logic [COL_W-1:0]                    col_o;
    logic [ROW_W-1:0]                    row_o;
    logic                                stall_i;
    logic                                locked_o;
    logic                                err_early_sof_o;
    logic                                err_missing_sof_o;
    logic                                err_overflow_o;
    logic                                clr_err_i;

    modport slave (
        input  channels_i, valid_i, sof_i, stall_i, clr_err_i,
        output stall_o, channels_o, valid_o, sof_o, eol_o, eof_o, col_o, row_o,
               locked_o, err_early_sof_o, err_missing_sof_o, err_overflow_o
    );

    modport master (
        output channels_i, valid_i, sof_i, stall_i, clr_err_i,
        input  stall_o, channels_o, valid_o, sof_o, eol_o, eof_o, col_o, row_o,
               locked_o, err_early_sof_o, err_missing_sof_o, err_overflow_o
    );
endinterface

`default_nettype wire

// File: rtl/stream_frame_tracker.sv
//==============================================================================
// Module      : stream_frame_tracker
// Description : Locks to frame boundaries of a buffered beat stream, tags each
//               beat with its position and delivers it through a 3-entry FIFO.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module stream_frame_tracker #(
    parameter int CHANNELS     = 1,
    parameter int DATA_WIDTH   = 16,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  wire logic             clk_i,
    input  wire logic             rst_n_i,
    stream_frame_tracker_if.slave bus
);
    localparam int COL_W = $clog2(FRAME_WIDTH);
    localparam int ROW_W = $clog2(FRAME_HEIGHT);
    localparam int c_depth = 3;
    localparam logic [COL_W-1:0] c_last_col = COL_W'(FRAME_WIDTH - 1);
    localparam logic [ROW_W-1:0] c_last_row = ROW_W'(FRAME_HEIGHT - 1);

    typedef struct packed {
        logic [CHANNELS-1:0][DATA_WIDTH-1:0] data;
        logic                                sof;
        logic                                eol;
        logic                                eof;
        logic [COL_W-1:0]                    col;
        logic [ROW_W-1:0]                    row;
    } entry_t;

    typedef enum logic [0:0] {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    state_t           r_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    entry_t           r_mem [c_depth];
    logic [1:0]       r_occ;
    logic             r_inflight;
    logic             r_err_early;
    logic             r_err_missing;
    logic             r_err_overflow;

    logic             w_stall;
    logic             w_origin;
    logic             w_write;
    logic             w_restart;
    logic             w_set_early;
    logic             w_set_missing;
    state_t           w_next_state;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_eol;
    logic             w_eof;
    logic             w_pop;
    logic             w_drop;
    logic             w_push;
    logic [1:0]       w_wr_idx;
    entry_t           w_entry;

    // Assert asynchronously, release on a clock edge after two flops.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    // Counting the in-flight read guarantees room for the beat it returns.
    assign w_stall  = ({1'b0, r_occ} + {2'b00, r_inflight}) >= 3'd3;
    assign w_origin = (r_col == '0) && (r_row == '0);

    always_comb begin
        w_write       = 1'b0;
        w_restart     = 1'b0;
        w_set_early   = 1'b0;
        w_set_missing = 1'b0;
        w_next_state  = r_state;
        if (bus.valid_i) begin
            if (r_state == ST_SYNC) begin
                if (bus.sof_i) begin
                    w_write      = 1'b1;
                    w_restart    = 1'b1;
                    w_next_state = ST_RUN;
                end
            end else if (bus.sof_i && !w_origin) begin
                w_write     = 1'b1;
                w_restart   = 1'b1;
                w_set_early = 1'b1;
            end else if (!bus.sof_i && w_origin) begin
                w_set_missing = 1'b1;
                w_next_state  = ST_SYNC;
            end else begin
                w_write = 1'b1;
            end
        end
    end

    assign w_col = w_restart ? '0 : r_col;
    assign w_row = w_restart ? '0 : r_row;
    assign w_eol = (w_col == c_last_col);
    assign w_eof = w_eol && (w_row == c_last_row);

    assign w_entry = '{data: bus.channels_i, sof: bus.sof_i, eol: w_eol,
                       eof: w_eof, col: w_col, row: w_row};

    assign w_pop    = (r_occ != 2'd0) && !bus.stall_i;
    assign w_drop   = w_write && (r_occ == 2'd3) && !w_pop;
    assign w_push   = w_write && !w_drop;
    assign w_wr_idx = w_pop ? (r_occ - 2'd1) : r_occ;

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state        <= ST_SYNC;
            r_col          <= '0;
            r_row          <= '0;
            r_err_early    <= 1'b0;
            r_err_missing  <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Dropped beats still advance position so the frame stays aligned.
            if (w_write) begin
                r_col <= w_eol ? '0 : (w_col + COL_W'(1));
                r_row <= w_eof ? '0 : (w_eol ? (w_row + ROW_W'(1)) : w_row);
            end
            r_err_early    <= w_set_early   | (r_err_early    & ~bus.clr_err_i);
            r_err_missing  <= w_set_missing | (r_err_missing  & ~bus.clr_err_i);
            r_err_overflow <= w_drop        | (r_err_overflow & ~bus.clr_err_i);
        end
    end

    // Shift-style FIFO: entry 0 is always the head, so outputs need no mux.
    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_occ      <= '0;
            r_inflight <= 1'b0;
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_inflight <= !w_stall;
            if (w_pop) begin
                for (int i = 0; i < c_depth - 1; i++) begin
                    r_mem[i] <= r_mem[i+1];
                end
            end
            if (w_push) begin
                r_mem[w_wr_idx] <= w_entry;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign bus.stall_o           = w_stall;
    assign bus.channels_o        = r_mem[0].data;
    assign bus.valid_o           = (r_occ != 2'd0);
    assign bus.sof_o             = r_mem[0].sof;
    assign bus.eol_o             = r_mem[0].eol;
    assign bus.eof_o             = r_mem[0].eof;
    assign bus.col_o             = r_mem[0].col;
    assign bus.row_o             = r_mem[0].row;
    assign bus.locked_o          = (r_state == ST_RUN);
    assign bus.err_early_sof_o   = r_err_early;
    assign bus.err_missing_sof_o = r_err_missing;
    assign bus.err_overflow_o    = r_err_overflow;

endmodule

`default_nettype wire
